// File: rtl/seq_divider_32.sv
// Restoring shift-subtract divider: one quotient bit per clock through a
// WIDTH+1-bit x + ~y + 1 trial subtraction, with sign and corner-case fix-up.
module seq_divider_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int              CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH+1:0] ONE_EXT  = {{(WIDTH+1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_rem, r_quo, r_dvs_mag, r_dvd_raw;
  logic [CW-1:0]    r_cnt;
  logic             r_neg_q, r_neg_r, r_dbz, r_ovf;
  logic             r_busy, r_done, r_div_by_zero, r_overflow;
  logic [WIDTH-1:0] r_quotient, r_remainder;

  logic [WIDTH-1:0] w_dvd_mag, w_dvs_mag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_sum;
  logic             w_ok;

  assign w_dvd_mag = (signed_op & dividend[WIDTH-1]) ? -dividend : dividend;
  assign w_dvs_mag = (signed_op & divisor[WIDTH-1])  ? -divisor  : divisor;

  // Trial subtraction rem - divisor as x + ~y + 1; the carry out means no borrow.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_sum   = {1'b0, w_shift} + {1'b0, ~{1'b0, r_dvs_mag}} + ONE_EXT;
  // A non-negative trial is below the divisor, so bit WIDTH is 0 whenever carry is set.
  assign w_ok    = w_sum[WIDTH+1] & ~w_sum[WIDTH];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // NOTE: default assigned first so no path through the case can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = (divisor == '0) ? FIX : CALC;
      CALC:    if (r_cnt == CNT_LAST) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // NOTE: every datapath register is reset too, so an aborted operation leaves no stale state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem         <= '0;
      r_quo         <= '0;
      r_dvs_mag     <= '0;
      r_dvd_raw     <= '0;
      r_cnt         <= '0;
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
      r_dbz         <= 1'b0;
      r_ovf         <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_neg_q       <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg_r       <= signed_op & dividend[WIDTH-1];
            r_rem         <= '0;
            r_quo         <= w_dvd_mag;
            r_dvs_mag     <= w_dvs_mag;
            r_dvd_raw     <= dividend;
            r_cnt         <= CNT_INIT;
            r_dbz         <= (divisor == '0);
            r_ovf         <= signed_op & (dividend == MOST_NEG) & (divisor == '1);
            r_div_by_zero <= 1'b0;
            r_overflow    <= 1'b0;
            r_busy        <= 1'b1;
          end
        end
        CALC: begin
          r_rem <= w_ok ? w_sum[WIDTH-1:0] : w_shift[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], w_ok};
          r_cnt <= r_cnt - CNT_LAST;
        end
        FIX: begin
          if (r_dbz) begin
            r_quotient    <= '1;
            r_remainder   <= r_dvd_raw;
            r_div_by_zero <= 1'b1;
            r_overflow    <= 1'b0;
          end else begin
            // Most-negative / -1 wraps back to most-negative through the magnitude path.
            r_quotient    <= r_neg_q ? -r_quo : r_quo;
            r_remainder   <= r_neg_r ? -r_rem : r_rem;
            r_div_by_zero <= 1'b0;
            r_overflow    <= r_ovf;
          end
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: r_busy <= 1'b0;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;
  assign overflow    = r_overflow;

endmodule
